// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the multiply/divide unit.
//   md_op_e    : operation code presented by ID/EX
//   md_state_e : md_unit sequencer states
//   DIV0_LO    : quotient returned for a divide by zero (all ones; sliced to
//                the unit width, so any WIDTH up to 64 is covered)
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } md_state_e;

  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/md_div_step.sv
// ---------------------------------------------------------------------------
// md_div_step
// One combinational restoring-division step.
//   rq_i      in  2*WIDTH  {remainder, quotient/dividend-shift} before the step
//   divisor_i in  WIDTH    divisor magnitude
//   rq_o      out 2*WIDTH  {remainder, quotient} after the step
// The pair is shifted left by one; if the shifted remainder is at least the
// divisor, the divisor is subtracted and a 1 enters the quotient LSB.
// ---------------------------------------------------------------------------
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] rq_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder is one bit wider during the trial so that the borrow out
  // of the subtraction (trial[WIDTH]) tells whether the divisor fitted.
  always_comb begin
    shifted = {rq_i[2*WIDTH-1:WIDTH], rq_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rq_o = {trial[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
    end else begin
      rq_o = {shifted[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Iterative multiply/divide unit sitting beside the EX-stage ALU. Owns HI/LO.
//   clk     in   1        rising-edge clock
//   rst     in   1        asynchronous active-low reset
//   start   in   1        op valid from ID/EX
//   op      in   3        md_op_e
//   rs_val  in   WIDTH    dividend / multiplicand / MTHI-MTLO source
//   rt_val  in   WIDTH    divisor / multiplier
//   flush   in   1        squash the in-flight op
//   busy    out  1        multiply/divide in progress
//   stall   out  1        hold PC/IFID/IDEX
//   done    out  1        one-cycle pulse, HI/LO written on the same edge
//   hilo    out  2*WIDTH  registered {HI,LO}
// Build option MD_FAST_MUL_EN: multiplies use a combinational multiplier and
// skip CALC (done two edges after start); divides stay iterative.
// ---------------------------------------------------------------------------
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  md_op_e             op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_md_op, is_signed, is_div_op;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand decode. Signed ops work on magnitudes; signs are reapplied in FIXUP.
  always_comb begin
    is_md_op  = op inside {MULT, MULTU, DIV, DIVU};
    is_signed = (op == MULT) || (op == DIV);
    is_div_op = (op == DIV) || (op == DIVU);
    abs_rs    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    abs_rt    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  // Shift-add multiply step: work holds {partial product, remaining multiplier}.
  // The carry of the add is kept by shifting it into the top bit.
  always_comb begin
    mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, work_q[WIDTH-1:1]};
  end

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rq_i      (work_q),
    .divisor_i (opnd_q),
    .rq_o      (div_nxt)
  );

  // Sign fix-up. The remainder follows the dividend's sign, which also makes
  // HI equal rs_val on a divide by zero (the restoring loop leaves |rs| there).
  always_comb begin
`ifdef MD_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, work_q[WIDTH-1:0]};
`else
    prod = work_q;
`endif
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = div0_q ? DIV0_LO[WIDTH-1:0]
                      : (neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer: IDLE accepts ops, CALC iterates, FIXUP writes HI/LO.
  // A flush in CALC/FIXUP abandons the op with HI/LO untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    work_d    = work_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (is_md_op) begin
            opnd_d    = is_div_op ? abs_rt : abs_rs;
            work_d    = {{WIDTH{1'b0}}, (is_div_op ? abs_rs : abs_rt)};
            neg_res_d = is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_d = is_signed && rs_val[WIDTH-1];
            is_div_d  = is_div_op;
            div0_d    = (rt_val == '0);
            cnt_d     = CNT_W'(WIDTH);
            state_d   = CALC;
`ifdef MD_FAST_MUL_EN
            if (!is_div_op) begin
              state_d = FIXUP;
            end
`endif
          end else if (op == MTHI) begin
            hi_d = rs_val;
          end else if (op == MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          work_d = is_div_q ? div_nxt : mul_nxt;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      work_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      work_q    <= work_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    stall = busy | (start & (state_q != IDLE));
    done  = done_q;
    hilo  = {hi_q, lo_q};
  end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Directed bench for md_unit: arithmetic corner cases, latency, MTHI/MTLO
// interaction with a busy unit, flush and asynchronous reset.
// Honours MD_FAST_MUL_EN for the expected multiply latency.
// ---------------------------------------------------------------------------
module tb_md_unit;
  import md_pkg::*;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst;
  logic        start;
  md_op_e      op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [63:0] hilo;

  int n_checks;
  int n_fail;

  md_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hilo   (hilo)
  );

  // Free-running clock; all driving and sampling happens on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; presents the op for exactly one rising edge.
  task automatic apply_stimulus(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    op     = NOP;
  endtask

  // Counts rising edges after the accepting edge until done is seen.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input md_op_e o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hilo, input int exp_lat);
    int lat;
    apply_stimulus(o, a, b);
    check_output({tag, " busy"}, {63'd0, busy}, 64'd1);
    wait_done(lat);
    check_output({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, " hilo"}, hilo, exp_hilo);
  endtask

  initial begin
    int  lat;
    bit  stall_ok;
    bit  done_seen;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = NOP;
    rs_val   = '0;
    rt_val   = '0;

    repeat (2) @(negedge clk);
    check_output("reset hilo", hilo, 64'd0);
    check_output("reset busy", {63'd0, busy}, 64'd0);
    check_output("reset stall", {63'd0, stall}, 64'd0);
    check_output("reset done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Chained ops: each one starts in the IDLE cycle right after the previous done.
    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
    run_op("mult -7*3", MULT, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_LAT);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_LAT);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, DIV_LAT);
    run_op("div -100/0", DIV, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FF9C_FFFF_FFFF, DIV_LAT);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT);
    run_op("multu 3*5", MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F, MUL_LAT);

    // MTHI presented while a multiply is busy is held off until IDLE.
    apply_stimulus(MULTU, 32'd6, 32'd7);
    start    = 1'b1;
    op       = MTHI;
    rs_val   = 32'h0000_1234;
    rt_val   = 32'd0;
    stall_ok = 1'b1;
    lat      = -1;
    for (int k = 1; k <= 40; k++) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check_output("mthi stall held", {63'd0, stall_ok}, 64'd1);
    check_output("mthi mul latency", 64'(lat), 64'(MUL_LAT));
    check_output("mthi not early", hilo, 64'h0000_0000_0000_002A);
    check_output("mthi stall released", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    op    = NOP;
    check_output("mthi applied", hilo, 64'h0000_1234_0000_002A);
    check_output("done single pulse", {63'd0, done}, 64'd0);

    // MTLO is single-cycle; then a divide is flushed mid-flight.
    apply_stimulus(MTLO, 32'h0000_00AA, 32'd0);
    check_output("mtlo hilo", hilo, 64'h0000_1234_0000_00AA);
    check_output("mtlo no busy", {63'd0, busy}, 64'd0);
    check_output("mtlo no done", {63'd0, done}, 64'd0);
    apply_stimulus(DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check_output("divu busy before flush", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("flush busy drop", {63'd0, busy}, 64'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
    end
    check_output("flush no done", {63'd0, done_seen}, 64'd0);
    check_output("flush hilo kept", hilo, 64'h0000_1234_0000_00AA);

    // Flush in the same IDLE cycle as a start drops the start.
    start  = 1'b1;
    op     = MTHI;
    rs_val = 32'h0000_DEAD;
    flush  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    op     = NOP;
    flush  = 1'b0;
    @(negedge clk);
    check_output("flush+start hilo", hilo, 64'h0000_1234_0000_00AA);
    check_output("flush+start busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a multiply.
    apply_stimulus(MULT, 32'd123, 32'd456);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async rst hilo", hilo, 64'd0);
    check_output("async rst busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
    end
    check_output("async rst no done", {63'd0, done_seen}, 64'd0);
    check_output("async rst hilo held", hilo, 64'd0);

    run_op("post-reset multu", MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F, MUL_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
